time_display_driver: RTL and testbench
======================================

// Module: time_display_driver
// PURPOSE
//  Consumer of the stopwatch time bus: snapshots time_min/time_sec, converts each to two
//  BCD digits with a sequential double-dabble engine, and time-multiplexes MM:SS onto a
//  4-digit common-anode 7-segment display. Colon dot blinks from time_ms.
//  Sits between time_counter outputs and the board display pins.
// PARAMETERS
//  SCAN_DIV        1000  clk_high_speed cycles per digit slot; legal range >= 2
//  BLANK_LEAD_ZERO 1     1: blank minutes-tens digit when it is 0; 0: always show it
// PORTS
//  clk_high_speed in   1   sole clock, all state on rising edge
//  rst_n          in   1   asynchronous reset, active low
//  time_ms        in   10  milliseconds 0..999 (drives dot blink only)
//  time_sec       in   6   seconds 0..63, binary
//  time_min       in   6   minutes 0..63, binary
//  seg            out  7   segments {g,f,e,d,c,b,a}, active low
//  an             out  4   digit anodes, active low; an[0] = rightmost digit
//  dp             out  1   decimal point, active low
//  digits_valid   out  1   high once the first conversion has committed
// BEHAVIOUR
//  Reset (async assert, sync release): seg=7'h7F, an=4'hF, dp=1, digits_valid=0;
//   BCD display regs=0, FSM=LOAD, scan_idx=0, prescaler=0.
//  Conversion FSM, free-running, 8 cycles/pass:
//   LOAD   (1 cyc): capture time_min, time_sec into shift regs; clear BCD scratch -> SHIFT
//   SHIFT  (6 cyc): per cycle, for min and sec in parallel: add 3 to every scratch nibble
//                   >= 5, then shift left 1 with next binary MSB in; 3-bit counter -> COMMIT
//   COMMIT (1 cyc): copy scratch {tens,ones} of min and sec to display regs;
//                   set digits_valid=1 (sticky until reset) -> LOAD
//  Input changes after LOAD do not affect the pass in progress.
//  Latency: input stable before LOAD -> display regs updated at COMMIT, <= 16 cycles.
//  Inputs 60..63 convert faithfully ("60".."63"); no clamping.
//  Scan: prescaler counts 0..SCAN_DIV-1; at SCAN_DIV-1 it wraps to 0 and scan_idx
//   increments mod 4 (3 -> 0).
//  Digit map: idx0 = sec ones, idx1 = sec tens, idx2 = min ones, idx3 = min tens.
//  Outputs are registered and reflect scan_idx with 1 cycle latency:
//   an = ~(4'b0001 << scan_idx)
//   seg = encode(selected digit), active low
//  Encode table: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 (hex, {g..a}).
//   Nibble > 9 is unreachable; if seen, seg=7'h7F.
//  Blanking:
//   - while digits_valid=0: seg=7'h7F on all digits, an still scans
//   - BLANK_LEAD_ZERO=1 and min tens==0: idx3 shows seg=7'h7F
//  dp: 0 only when scan_idx==2 and time_ms < 500 (sampled the same cycle the output
//   register loads); 1 otherwise. time_ms > 999 is treated as >= 500.
//  Reset mid-pass: scratch is discarded; no partial value ever reaches the display regs.
// TESTING
//  1 Hold rst_n=0 -> seg=7F, an=F, dp=1, digits_valid=0; release -> digits_valid=1
//    after 8 cycles.
//  2 SCAN_DIV=4, min=37, sec=59, ms=0 -> an steps E,D,B,7 every 4 cycles.
//    seg: idx0=10 (9), idx1=12 (5), idx2=78 (7), idx3=30 (3); dp=0 only when an=B.
//  3 min=5, sec=0, BLANK_LEAD_ZERO=1 -> idx3 seg=7F, idx2 seg=12.
//    With BLANK_LEAD_ZERO=0, idx3 seg=40.
//  4 ms=499 then 500 at scan_idx=2 -> dp 0 then 1 on the next output update.
//  5 min=63, sec=63 -> digits 6,3,6,3.
//    Change sec 63->10 during SHIFT -> that pass commits 63; next pass commits 10.
//  6 Assert rst_n=0 mid-SHIFT -> outputs reset immediately (async).
//    After release, first commit reflects the then-current inputs.

Source files
------------

// File: rtl/time_display_driver_if.sv
// Stopwatch time bus plus the display pins it drives, bundled for the display driver.
// master = time bus producer, slave = display driver.
interface time_display_driver_if;
   logic [9:0] time_ms;
   logic [5:0] time_sec;
   logic [5:0] time_min;
   logic [6:0] seg;
   logic [3:0] an;
   logic       dp;
   logic       digits_valid;

   modport master (
      output time_ms, time_sec, time_min,
      input  seg, an, dp, digits_valid
   );

   modport slave (
      input  time_ms, time_sec, time_min,
      output seg, an, dp, digits_valid
   );
endinterface

// File: rtl/time_display_driver.sv
// MM:SS display driver: snapshots the time bus, converts min/sec to BCD with a
// sequential double-dabble pass, and scans the result onto a 4-digit common-anode display.
module time_display_driver #(
   parameter int unsigned SCAN_DIV        = 1000,
   parameter bit          BLANK_LEAD_ZERO = 1'b1
) (
   input logic                  clk_high_speed,
   input logic                  rst_n,
   time_display_driver_if.slave bus
);

   localparam int unsigned PW = $clog2(SCAN_DIV);

   typedef enum logic [1:0] {LOAD, SHIFT, COMMIT} state_t;

   state_t          state_q, state_d;
   logic [2:0]      bit_cnt;
   logic [5:0]      min_sh, sec_sh;
   logic [7:0]      min_scr, sec_scr;
   logic [7:0]      min_bcd, sec_bcd;
   logic            valid_q;
   logic [PW-1:0]   prescaler;
   logic [1:0]      scan_idx;
   logic [3:0]      digit;
   logic            blank;
   logic [6:0]      seg_q;
   logic [3:0]      an_q;
   logic            dp_q;

   // One double-dabble step: correct each BCD nibble, then shift the next binary bit in.
   function automatic logic [7:0] dabble(input logic [7:0] s, input logic b);
      logic [3:0] t, o;
      t = (s[7:4] >= 4'd5) ? s[7:4] + 4'd3 : s[7:4];
      o = (s[3:0] >= 4'd5) ? s[3:0] + 4'd3 : s[3:0];
      return {t[2:0], o, b};
   endfunction

   function automatic logic [6:0] encode(input logic [3:0] d);
      case (d)
         4'd0:    return 7'h40;
         4'd1:    return 7'h79;
         4'd2:    return 7'h24;
         4'd3:    return 7'h30;
         4'd4:    return 7'h19;
         4'd5:    return 7'h12;
         4'd6:    return 7'h02;
         4'd7:    return 7'h78;
         4'd8:    return 7'h00;
         4'd9:    return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   always_ff @(posedge clk_high_speed or negedge rst_n) begin
      if (!rst_n) state_q <= LOAD;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         LOAD:    state_d = SHIFT;
         SHIFT:   if (bit_cnt == 3'd5) state_d = COMMIT;
         COMMIT:  state_d = LOAD;
         default: state_d = LOAD;
      endcase
   end

   // Scratch is reset along with the FSM so an interrupted pass never reaches the display regs.
   always_ff @(posedge clk_high_speed or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt <= '0;
         min_sh  <= '0;
         sec_sh  <= '0;
         min_scr <= '0;
         sec_scr <= '0;
         min_bcd <= '0;
         sec_bcd <= '0;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            LOAD: begin
               min_sh  <= bus.time_min;
               sec_sh  <= bus.time_sec;
               min_scr <= '0;
               sec_scr <= '0;
               bit_cnt <= '0;
            end
            SHIFT: begin
               min_scr <= dabble(min_scr, min_sh[5]);
               sec_scr <= dabble(sec_scr, sec_sh[5]);
               min_sh  <= {min_sh[4:0], 1'b0};
               sec_sh  <= {sec_sh[4:0], 1'b0};
               bit_cnt <= bit_cnt + 3'd1;
            end
            COMMIT: begin
               min_bcd <= min_scr;
               sec_bcd <= sec_scr;
               valid_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_high_speed or negedge rst_n) begin
      if (!rst_n) begin
         prescaler <= '0;
         scan_idx  <= '0;
      end else if (prescaler == PW'(SCAN_DIV - 1)) begin
         prescaler <= '0;
         scan_idx  <= scan_idx + 2'd1;
      end else begin
         prescaler <= prescaler + PW'(1);
      end
   end

   always_comb begin
      digit = 4'd0;
      blank = !valid_q;
      case (scan_idx)
         2'd0: digit = sec_bcd[3:0];
         2'd1: digit = sec_bcd[7:4];
         2'd2: digit = min_bcd[3:0];
         2'd3: begin
            digit = min_bcd[7:4];
            if (BLANK_LEAD_ZERO && min_bcd[7:4] == 4'd0) blank = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_high_speed or negedge rst_n) begin
      if (!rst_n) begin
         seg_q <= 7'h7F;
         an_q  <= 4'hF;
         dp_q  <= 1'b1;
      end else begin
         seg_q <= blank ? 7'h7F : encode(digit);
         an_q  <= ~(4'b0001 << scan_idx);
         dp_q  <= !(scan_idx == 2'd2 && bus.time_ms < 10'd500);
      end
   end

   assign bus.seg          = seg_q;
   assign bus.an           = an_q;
   assign bus.dp           = dp_q;
   assign bus.digits_valid = valid_q;

endmodule

// File: tb/tb_time_display_driver.sv
// Bench for time_display_driver: two instances (leading-zero blanking on/off) checked each
// cycle against a cycle-count/decimal-arithmetic model of the display.
module tb_time_display_driver;

   localparam int SD = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   time_display_driver_if bus_a ();
   time_display_driver_if bus_b ();

   time_display_driver #(.SCAN_DIV(SD), .BLANK_LEAD_ZERO(1'b1)) u_a (
      .clk_high_speed(clk), .rst_n(rst_n), .bus(bus_a.slave));
   time_display_driver #(.SCAN_DIV(SD), .BLANK_LEAD_ZERO(1'b0)) u_b (
      .clk_high_speed(clk), .rst_n(rst_n), .bus(bus_b.slave));

   int passed = 0;
   int total  = 0;
   int k      = 0;
   int cur_min, cur_sec, cur_ms;
   int hist_min [4096];
   int hist_sec [4096];
   int hist_ms  [4096];
   logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      total++;
      assert (obs === exp_v) passed++;
      else $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp_v);
   endtask

   task automatic drive(input int m, input int s, input int ms);
      cur_min = m; cur_sec = s; cur_ms = ms;
      bus_a.time_min = 6'(m); bus_a.time_sec = 6'(s); bus_a.time_ms = 10'(ms);
      bus_b.time_min = 6'(m); bus_b.time_sec = 6'(s); bus_b.time_ms = 10'(ms);
   endtask

   // After edge kk the outputs show the digit slot held before that edge; the display regs
   // then hold the last pass that committed on an edge multiple of 8, sampled 7 edges earlier.
   function automatic logic [6:0] exp_seg(input int kk, input bit blz);
      int idx, c, m, s, d;
      idx = ((kk - 1) / SD) % 4;
      c   = 8 * ((kk - 1) / 8);
      if (c == 0) return 7'h7F;
      m = hist_min[c - 7];
      s = hist_sec[c - 7];
      case (idx)
         0:       d = s % 10;
         1:       d = s / 10;
         2:       d = m % 10;
         default: d = m / 10;
      endcase
      if (idx == 3 && blz && d == 0) return 7'h7F;
      return seg_tbl[d];
   endfunction

   task automatic check_reset();
      chk("rst_seg_a", {1'b0, bus_a.seg}, 8'h7F);
      chk("rst_an_a", {4'h0, bus_a.an}, 8'h0F);
      chk("rst_dp_a", {7'h0, bus_a.dp}, 8'h01);
      chk("rst_valid_a", {7'h0, bus_a.digits_valid}, 8'h00);
      chk("rst_seg_b", {1'b0, bus_b.seg}, 8'h7F);
      chk("rst_valid_b", {7'h0, bus_b.digits_valid}, 8'h00);
   endtask

   task automatic step();
      int idx;
      @(posedge clk);
      k++;
      hist_min[k] = cur_min;
      hist_sec[k] = cur_sec;
      hist_ms[k]  = cur_ms;
      #1;
      idx = ((k - 1) / SD) % 4;
      chk("an_a", {4'h0, bus_a.an}, {4'h0, ~(4'b0001 << idx)});
      chk("an_b", {4'h0, bus_b.an}, {4'h0, ~(4'b0001 << idx)});
      chk("seg_a", {1'b0, bus_a.seg}, {1'b0, exp_seg(k, 1'b1)});
      chk("seg_b", {1'b0, bus_b.seg}, {1'b0, exp_seg(k, 1'b0)});
      chk("dp_a", {7'h0, bus_a.dp}, (idx == 2 && hist_ms[k] < 500) ? 8'h00 : 8'h01);
      chk("valid_a", {7'h0, bus_a.digits_valid}, (k >= 8) ? 8'h01 : 8'h00);
      chk("valid_b", {7'h0, bus_b.digits_valid}, (k >= 8) ? 8'h01 : 8'h00);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      drive(37, 59, 0);
      #2 rst_n = 1'b0;
      #10 check_reset();
      run(0);
      @(negedge clk) rst_n = 1'b1;
      k = 0;

      // Steady 37:59 through several full scans; dp low on the minutes-ones slot.
      run(80);

      // 05:00 exercises leading-zero blanking (instance a) versus a shown zero (instance b).
      drive(5, 0, 0);
      run(40);

      // dp threshold at 499/500, toggled every cycle.
      for (int i = 0; i < 24; i++) begin
         drive(5, 0, (i % 2 == 0) ? 499 : 500);
         step();
      end

      // 63:63, then seconds change in the middle of a conversion pass.
      drive(63, 63, 750);
      while (k % 8 != 3) step();
      run(8);
      drive(63, 10, 750);
      run(30);

      // Random time-bus activity, including out-of-range milliseconds.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 2) == 0)
            drive(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                  int'($urandom_range(0, 1023)));
         step();
      end

      // Asynchronous reset in the middle of a conversion pass.
      while (k % 8 != 4) step();
      #2 rst_n = 1'b0;
      #1 check_reset();
      drive(int'($urandom_range(10, 63)), int'($urandom_range(0, 63)), 100);
      @(negedge clk) rst_n = 1'b1;
      k = 0;
      run(48);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
